// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES decrypt round controller
package aes_pkg;
  localparam int AES_BLK = 128;
  localparam int NR_DEF = 10;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {WHITEN = 2'd0, FULL = 2'd1, FINAL = 2'd2} rd_mode_t;
endpackage

// File: rtl/aes_dec_pass_sched.sv
// aes_dec_pass_sched: maps a pass number to its datapath mode and round-key index
module aes_dec_pass_sched
  import aes_pkg::*;
#(
  parameter int NR = NR_DEF
) (
  input  logic [3:0] pass,
  output rd_mode_t   mode,
  output logic [3:0] key_idx
);
  localparam logic [3:0] NRB = 4'(NR);
  // pass 0 only whitens, pass NR skips InvMixColumns; keys run NR down to 0
  always_comb begin
    mode = pass == 4'd0 ? WHITEN : pass == NRB ? FINAL : FULL;
    key_idx = NRB - pass;
  end
endmodule

// File: rtl/aes_dec_round_ctrl.sv
// aes_dec_round_ctrl: sequences NR+1 datapath passes to decrypt one AES block
module aes_dec_round_ctrl
  import aes_pkg::*;
#(
  parameter int ROUND_LAT = 4,
  parameter int NR = NR_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:AES_BLK-1] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:AES_BLK-1] out_data,
  output logic               rd_start,
  output logic [1:0]         rd_mode,
  output logic [3:0]         rd_key_idx,
  output logic [0:AES_BLK-1] rd_state,
  input  logic [0:AES_BLK-1] rd_result,
  output logic               busy
);
  localparam logic [3:0] NRB = 4'(NR);
  localparam logic [3:0] LAST = 4'(ROUND_LAT - 1);
  state_t st;
  logic [3:0] pass, wcnt, nxt_pass, s_key;
  rd_mode_t s_mode;
  logic [0:AES_BLK-1] sreg;
  assign nxt_pass = st == IDLE ? 4'd0 : pass + 4'd1;
  assign out_data = sreg;
  assign rd_state = sreg;
  aes_dec_pass_sched #(.NR(NR)) u_sched (
    .pass(nxt_pass),
    .mode(s_mode),
    .key_idx(s_key)
  );
  // control FSM; pass fields are latched on entry to ISSUE so they hold through WAIT
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      pass <= 4'd0;
      wcnt <= 4'd0;
      sreg <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      rd_start <= 1'b0;
      rd_mode <= WHITEN;
      rd_key_idx <= 4'd0;
    end else begin
      rd_start <= 1'b0;
      unique case (st)
        IDLE: if (in_valid) begin
          sreg <= in_data;
          pass <= 4'd0;
          st <= ISSUE;
          in_ready <= 1'b0;
          busy <= 1'b1;
          rd_start <= 1'b1;
          rd_mode <= s_mode;
          rd_key_idx <= s_key;
        end
        ISSUE: begin
          st <= WAIT;
          wcnt <= 4'd0;
        end
        WAIT: if (wcnt == LAST) begin
          sreg <= rd_result;
          pass <= pass + 4'd1;
          if (pass == NRB) begin
            st <= DONE;
            out_valid <= 1'b1;
          end else begin
            st <= ISSUE;
            rd_start <= 1'b1;
            rd_mode <= s_mode;
            rd_key_idx <= s_key;
          end
        end else wcnt <= wcnt + 4'd1;
        DONE: if (out_ready) begin
          st <= IDLE;
          out_valid <= 1'b0;
          busy <= 1'b0;
          in_ready <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// tb_aes_dec_round_ctrl: scoreboard bench with an AES inverse-round datapath model
module tb_aes_dec_round_ctrl;
  localparam int NR = 10;
  localparam logic [0:127] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [0:127] PT2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [0:127] CT3 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT3 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] GARB = {4{32'hdeadbeef}};

  logic clock = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[256];
  logic [7:0] isb[256];

  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [0:2047] kexp(input logic [0:127] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [0:2047] r;
    rc = 8'h01;
    r = '0;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  function automatic logic [0:127] dround(input logic [0:127] s, input logic [1:0] m, input logic [0:127] k);
    logic [0:127] t, u;
    logic [7:0] a0, a1, a2, a3;
    if (m == 2'd0) return s ^ k;
    for (int b = 0; b < 16; b++)
      t[8*b +: 8] = isb[s[8*((b % 4) + 4*(((b / 4) - (b % 4) + 4) % 4)) +: 8]];
    u = t ^ k;
    if (m == 2'd1)
      for (int c = 0; c < 4; c++) begin
        a0 = u[32*c +: 8];
        a1 = u[32*c+8 +: 8];
        a2 = u[32*c+16 +: 8];
        a3 = u[32*c+24 +: 8];
        u[32*c +: 32] = {gm(a0, 8'd14) ^ gm(a1, 8'd11) ^ gm(a2, 8'd13) ^ gm(a3, 8'd9),
                         gm(a0, 8'd9) ^ gm(a1, 8'd14) ^ gm(a2, 8'd11) ^ gm(a3, 8'd13),
                         gm(a0, 8'd13) ^ gm(a1, 8'd9) ^ gm(a2, 8'd14) ^ gm(a3, 8'd11),
                         gm(a0, 8'd11) ^ gm(a1, 8'd13) ^ gm(a2, 8'd9) ^ gm(a3, 8'd14)};
      end
    return u;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = (g == 0) ? 4 : 1;
    localparam int LATV = (NR + 1) * (L + 1) + 1;
    logic rst_n, in_valid, in_ready, out_valid, out_ready, rd_start, busy;
    logic done = 1'b0;
    logic [0:127] in_data, out_data, rd_state, rd_result;
    logic [0:2047] rks;
    logic [1:0] rd_mode;
    logic [3:0] rd_key_idx;
    logic [0:127] qd[$];
    int qa[$];
    int pass_n;

    aes_dec_round_ctrl #(.ROUND_LAT(L), .NR(NR)) dut (
      .clock(clock),
      .reset(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .rd_start(rd_start),
      .rd_mode(rd_mode),
      .rd_key_idx(rd_key_idx),
      .rd_state(rd_state),
      .rd_result(rd_result),
      .busy(busy)
    );

    task automatic chk_rst(input string nm);
      chk(in_ready && !out_valid && !rd_start && !busy && rd_mode == 2'd0 && rd_key_idx == 4'd0, nm,
          {in_ready, out_valid, rd_start, busy, rd_mode, rd_key_idx}, 10'b10_0000_0000);
      chk(out_data == '0 && rd_state == '0, {nm, "_data"}, out_data ^ rd_state, 0);
    endtask

    task automatic send(input logic [0:127] d, input logic [0:127] e, output int acc);
      int n;
      in_data = d;
      in_valid = 1'b1;
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 200) begin
        @(negedge clock);
        n++;
      end
      chk(in_ready, "accept", in_ready, 1);
      acc = cyc;
      qd.push_back(e);
      qa.push_back(cyc);
      @(posedge clock);
      #1 in_valid = 1'b0;
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (qd.size() != 0 && n < 300) begin
        @(posedge clock);
        n++;
      end
      chk(qd.size() == 0, "drain", qd.size(), 0);
      #1;
    endtask

    // datapath model: answers each rd_start with one inverse round, valid only in the capture cycle
    initial begin
      logic [1:0] m, em;
      logic [3:0] k, ek;
      logic [0:127] s;
      bit ab;
      int lc;
      pass_n = 0;
      lc = 0;
      rd_result = GARB;
      forever begin
        @(negedge clock);
        rd_result = GARB;
        if (!rst_n || (in_valid && in_ready)) pass_n = 0;
        if (rd_start && rst_n) begin
          m = rd_mode;
          k = rd_key_idx;
          s = rd_state;
          ab = 0;
          em = pass_n == 0 ? 2'd0 : pass_n == NR ? 2'd2 : 2'd1;
          ek = pass_n == 0 ? 4'(NR) : pass_n == NR ? 4'd0 : 4'(NR - pass_n);
          chk(m == em, "sched_mode", m, em);
          chk(k == ek, "sched_key", k, ek);
          if (pass_n > 0) chk(cyc - lc == L + 1, "start_spacing", cyc - lc, L + 1);
          lc = cyc;
          pass_n++;
          for (int i = 0; i < L; i++) begin
            @(negedge clock);
            if (!rst_n) ab = 1;
            if (!ab) begin
              chk(!rd_start && rd_mode == m && rd_key_idx == k, "wait_hold_ctl",
                  {rd_start, rd_mode, rd_key_idx}, {1'b0, m, k});
              chk(rd_state == s, "wait_hold_state", rd_state, s);
            end
          end
          if (!ab) rd_result = dround(s, m, rks[128*k +: 128]);
        end
      end
    end

    // output monitor: compares each presented plaintext against the scoreboard head
    initial begin
      bit first, popd;
      first = 1;
      popd = 0;
      forever begin
        @(negedge clock);
        if (!rst_n) begin
          first = 1;
          popd = 0;
        end else begin
          if (popd) begin
            chk(!out_valid && in_ready && !busy, "release_idle", {out_valid, in_ready, busy}, 3'b010);
            popd = 0;
          end
          if (out_valid) begin
            chk(qd.size() > 0, "out_valid_expected", qd.size(), 1);
            if (qd.size() > 0) begin
              if (first) begin
                chk(cyc - qa[0] == LATV, "latency", cyc - qa[0], LATV);
                chk(pass_n == NR + 1, "pass_count", pass_n, NR + 1);
                first = 0;
              end
              chk(out_data == qd[0], "out_data", out_data, qd[0]);
              chk(!in_ready && !rd_start && busy, "done_flags", {in_ready, rd_start, busy}, 3'b001);
              if (out_ready) begin
                void'(qd.pop_front());
                void'(qa.pop_front());
                first = 1;
                popd = 1;
              end
            end
          end
        end
      end
    end

    // stimulus: the default-latency instance runs every scenario, the other the C.1 latency case
    initial begin
      int a1, a2, n;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      @(posedge clock);
      rks = kexp(K1);
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;
      @(negedge clock);
      chk_rst("reset_release");
      @(posedge clock);
      #1 send(CT1, PT1, a1);
      drain();
      if (g == 0) begin
        out_ready = 1'b0;
        send(CT1, PT1, a1);
        n = 0;
        while (!out_valid && n < 200) begin
          @(negedge clock);
          n++;
        end
        chk(out_valid, "stall_reach_done", out_valid, 1);
        repeat (20) @(posedge clock);
        #1 out_ready = 1'b1;
        drain();
        rks = kexp(K2);
        send(CT2, PT2, a1);
        send(CT3, PT3, a2);
        chk(a2 - a1 == LATV + 1, "b2b_accept", a2 - a1, LATV + 1);
        drain();
        rks = kexp(K1);
        send(CT1, PT1, a1);
        n = 0;
        while (pass_n < 6 && n < 100) begin
          @(negedge clock);
          n++;
        end
        chk(pass_n >= 6, "reach_pass5", pass_n, 6);
        @(negedge clock);
        qd.delete();
        qa.delete();
        #2 rst_n = 1'b0;
        #1 chk_rst("reset_async");
        repeat (8) @(posedge clock);
        #3 rst_n = 1'b1;
        @(negedge clock);
        chk_rst("reset_after_abort");
        @(posedge clock);
        #1 send(CT1, PT1, a1);
        drain();
      end
      repeat (3) @(posedge clock);
      done = 1'b1;
    end
  end

  initial begin
    logic [7:0] v, inv, r, s;
    for (int x = 0; x < 256; x++) begin
      v = x[7:0];
      inv = 8'h00;
      if (x != 0) begin
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gm(r, v);
        inv = r;
      end
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      sb[x] = s;
      isb[s] = v;
    end
    fork
      wait (u[0].done && u[1].done);
      #100000;
    join_any
    if (!(u[0].done && u[1].done)) begin
      checks++;
      errors++;
      $display("FAIL timeout: got done=%b%b expected 11", u[0].done, u[1].done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
